wci_axil_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one WCI::AXI AXI4-Lite master (wcim0) among NREQ control requesters.

---
 rtl/wci_axil_arbiter_pkg.sv | 21 ++
 rtl/wci_axil_arbiter_if.sv | 31 +++
 rtl/wci_axil_arbiter_rr_arbiter.sv | 32 +++
 rtl/wci_axil_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wci_axil_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wci_axil_arbiter_pkg.sv
// Shared types and constants for the WCI AXI4-Lite control arbiter.
package wci_axil_pkg;

  // Sequencer states: one AXI transaction in flight at a time.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_W = 3'd1,
    S_ADDR_R = 3'd2,
    S_RESP_W = 3'd3,
    S_RESP_R = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;

  // Read data returned when a transaction is abandoned by the watchdog.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_C0DE;

endpackage

// File: rtl/wci_axil_arbiter_if.sv
// AXI4-Lite bus bundle (single outstanding, no IDs) between the arbiter and a slave.
interface wci_axil_arbiter_if;

  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/wci_axil_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      // NOTE: blocking assignments here, since j and any must update in program order within one evaluation.
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wci_axil_arbiter.sv
// Round-robin arbiter/sequencer sharing one AXI4-Lite master (wcim0) among NREQ requesters.
// Optional build macro WCI_TIMEOUT_EN adds a watchdog that forces completion after TIMEOUT cycles.
module wci_axil_arbiter
  import wci_axil_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [2:0]  PROT    = 3'b000,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 oped_clk125,
  input  logic                 oped_reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_wstrb,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [1:0]           rsp_resp,
  output logic                 rsp_timeout,
  output logic                 busy,
  wci_axil_arbiter_if.master   wcim0
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, gnt_idx, owner;
  logic [NREQ-1:0] gnt_vec;
  logic            gnt_any, grant_go, active, capture;
  logic [31:0]     lat_addr, lat_wdata;
  logic [3:0]      lat_wstrb;
  logic            aw_done, w_done;
  logic            aw_fire, w_fire, ar_fire, b_fire, r_fire, tmo_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_vec),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign grant_go = (state == S_IDLE) && gnt_any;
  assign active   = state inside {S_ADDR_W, S_ADDR_R, S_RESP_W, S_RESP_R};
  assign aw_fire  = wcim0.awvalid && wcim0.awready;
  assign w_fire   = wcim0.wvalid  && wcim0.wready;
  assign ar_fire  = wcim0.arvalid && wcim0.arready;
  assign b_fire   = wcim0.bready  && wcim0.bvalid;
  assign r_fire   = wcim0.rready  && wcim0.rvalid;
  assign capture  = active && (state_nxt == S_DONE);

`ifdef WCI_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Watchdog: cleared at grant, counts every cycle a transaction is on the bus.
  always_ff @(posedge oped_clk125) begin
    if (oped_reset)    tmo_cnt <= '0;
    else if (grant_go) tmo_cnt <= '0;
    else if (active)   tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit = active && (tmo_cnt >= 32'(TIMEOUT - 1));

  // Flag completions that were forced by the watchdog rather than a slave response.
  always_ff @(posedge oped_clk125) begin
    if (oped_reset)   rsp_timeout <= 1'b0;
    else if (capture) rsp_timeout <= !(b_fire || r_fire);
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge oped_clk125) begin
    // NOTE: non-blocking for every sequential assignment so all flops see pre-edge values.
    if (oped_reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; a real handshake takes precedence over the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (gnt_any) state_nxt = req_write[gnt_idx] ? S_ADDR_W : S_ADDR_R;
      S_ADDR_W: if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = S_RESP_W;
                else if (tmo_hit)                               state_nxt = S_DONE;
      S_ADDR_R: if (ar_fire)      state_nxt = S_RESP_R;
                else if (tmo_hit) state_nxt = S_DONE;
      S_RESP_W: if (b_fire || tmo_hit) state_nxt = S_DONE;
      S_RESP_R: if (r_fire || tmo_hit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; grants are suppressed while reset is held.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    wcim0.awvalid = 1'b0;
    wcim0.wvalid  = 1'b0;
    wcim0.bready  = 1'b0;
    wcim0.arvalid = 1'b0;
    wcim0.rready  = 1'b0;
    case (state)
      S_IDLE:   if (!oped_reset) req_ready = gnt_vec;
      S_ADDR_W: begin
        wcim0.awvalid = !aw_done;
        wcim0.wvalid  = !w_done;
      end
      S_ADDR_R: wcim0.arvalid = 1'b1;
      S_RESP_W: wcim0.bready  = 1'b1;
      S_RESP_R: wcim0.rready  = 1'b1;
      S_DONE:   rsp_valid[owner] = 1'b1;
      default:  ;
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign wcim0.awaddr = lat_addr;
  assign wcim0.araddr = lat_addr;
  assign wcim0.wdata  = lat_wdata;
  assign wcim0.wstrb  = lat_wstrb;
  assign wcim0.awprot = PROT;
  assign wcim0.arprot = PROT;

  // Request latch, round-robin pointer, per-channel handshake flags and response capture.
  always_ff @(posedge oped_clk125) begin
    if (oped_reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      if (grant_go) begin
        owner     <= gnt_idx;
        lat_addr  <= req_addr[32*gnt_idx +: 32];
        lat_wdata <= req_wdata[32*gnt_idx +: 32];
        lat_wstrb <= req_wstrb[4*gnt_idx +: 4];
        rr_ptr    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (capture) begin
        if (b_fire) begin
          rsp_data <= '0;
          rsp_resp <= wcim0.bresp;
        end else if (r_fire) begin
          rsp_data <= wcim0.rdata;
          rsp_resp <= wcim0.rresp;
        end else begin
          rsp_data <= TIMEOUT_DATA;
          rsp_resp <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_wci_axil_arbiter.sv
// Directed self-checking bench for wci_axil_arbiter (NREQ=4, TIMEOUT=16).
// The slave side of the bus is driven by hand, cycle by cycle.
module tb_wci_axil_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_wstrb;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_resp;
  logic         rsp_timeout, busy;

  int tests = 0;
  int fails = 0;

  wci_axil_arbiter_if wcim0 ();

  wci_axil_arbiter #(.NREQ(4), .PROT(3'b000), .TIMEOUT(16)) dut (
    .oped_clk125 (clk),
    .oped_reset  (rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .wcim0       (wcim0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[i]        = w;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
    req_wstrb[4*i +: 4]   = s;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int lat;
    int stray;

    rst = 1'b1;
    req_valid = 4'hF; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    wcim0.awready = 0; wcim0.wready = 0; wcim0.bvalid = 0; wcim0.bresp = 0;
    wcim0.arready = 0; wcim0.rvalid = 0; wcim0.rdata = 0; wcim0.rresp = 0;

    // Reset state (requests pending must not be granted while reset is held)
    repeat (3) cyc();
    check("rst_busy",      busy,          0);
    check("rst_req_ready", req_ready,     0);
    check("rst_rsp_valid", rsp_valid,     0);
    check("rst_rsp_data",  rsp_data,      0);
    check("rst_rsp_resp",  rsp_resp,      0);
    check("rst_timeout",   rsp_timeout,   0);
    check("rst_awvalid",   wcim0.awvalid, 0);
    check("rst_wvalid",    wcim0.wvalid,  0);
    check("rst_arvalid",   wcim0.arvalid, 0);
    check("rst_bready",    wcim0.bready,  0);
    check("rst_rready",    wcim0.rready,  0);
    req_valid = '0;
    rst = 1'b0;
    cyc();

    // All four request reads at once; grants rotate 0,1,2,3,0 with one in flight
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
    wcim0.arready = 1; wcim0.rvalid = 1; wcim0.rresp = 2'b00;
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("rr_grant",    req_ready, 32'(1) << order[n]);
      check("rr_idle",     busy, 0);
      cyc();
      wcim0.rdata = 32'h5000_0000 + 32'(n);
      #1;
      check("rr_arvalid",  wcim0.arvalid, 1);
      check("rr_araddr",   wcim0.araddr, 32'h100 + 32'(4 * order[n]));
      check("rr_no_grant", req_ready, 0);
      check("rr_no_aw",    wcim0.awvalid, 0);
      cyc(); #1;
      check("rr_rready",   wcim0.rready, 1);
      check("rr_no_grant", req_ready, 0);
      cyc(); #1;
      check("rr_rsp",      rsp_valid, 32'(1) << order[n]);
      check("rr_rdata",    rsp_data, 32'h5000_0000 + 32'(n));
      check("rr_no_grant", req_ready, 0);
      cyc();
      if (n == 4) req_valid = '0;
    end
    wcim0.arready = 0; wcim0.rvalid = 0;

    // Single write from req0, fully ready slave: AW/W at T+1, rsp_valid at T+3
    set_req(0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    req_valid = 4'b0001;
    #1 check("w1_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0; wcim0.awready = 1; wcim0.wready = 1;
    #1;
    check("w1_awvalid", wcim0.awvalid, 1);
    check("w1_wvalid",  wcim0.wvalid, 1);
    check("w1_awaddr",  wcim0.awaddr, 32'h10);
    check("w1_wdata",   wcim0.wdata, 32'hA5A5_5A5A);
    check("w1_wstrb",   wcim0.wstrb, 4'hF);
    check("w1_awprot",  wcim0.awprot, 3'b000);
    check("w1_busy",    busy, 1);
    cyc();
    wcim0.awready = 0; wcim0.wready = 0; wcim0.bvalid = 1; wcim0.bresp = 2'b00;
    #1;
    check("w1_aw_drop", wcim0.awvalid, 0);
    check("w1_w_drop",  wcim0.wvalid, 0);
    check("w1_bready",  wcim0.bready, 1);
    check("w1_no_rsp",  rsp_valid, 0);
    cyc();
    wcim0.bvalid = 0;
    #1;
    check("w1_rsp",     rsp_valid, 4'b0001);
    check("w1_resp",    rsp_resp, 2'b00);
    check("w1_data",    rsp_data, 0);
    check("w1_timeout", rsp_timeout, 0);
    cyc(); #1;
    check("w1_rsp_once", rsp_valid, 0);
    check("w1_idle",     busy, 0);

    // Read from req2, slow R response with SLVERR; req0 arrives meanwhile and must wait
    set_req(2, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    set_req(0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'b0011);
    req_valid = 4'b0100;
    #1 check("r3_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0; wcim0.arready = 1;
    #1;
    check("r3_arvalid", wcim0.arvalid, 1);
    check("r3_araddr",  wcim0.araddr, 32'h40);
    cyc();
    wcim0.arready = 0; req_valid = 4'b0001;
    #1;
    check("r3_rready",  wcim0.rready, 1);
    check("r3_ar_drop", wcim0.arvalid, 0);
    check("r3_wait",    req_ready, 0);
    repeat (4) begin
      cyc(); #1;
      check("r3_no_rsp", rsp_valid, 0);
      check("r3_wait",   req_ready, 0);
    end
    cyc();
    wcim0.rvalid = 1; wcim0.rdata = 32'h1234_5678; wcim0.rresp = 2'b10;
    #1 check("r3_rready_hold", wcim0.rready, 1);
    cyc();
    wcim0.rvalid = 0;
    #1;
    check("r3_rsp",  rsp_valid, 4'b0100);
    check("r3_data", rsp_data, 32'h1234_5678);
    check("r3_resp", rsp_resp, 2'b10);
    cyc(); #1;
    check("w4_grant", req_ready, 4'b0001);

    // Write where W handshakes three cycles before AW; stray bvalid during address phase
    cyc();
    req_valid = '0; wcim0.wready = 1;
    #1;
    check("w4_awvalid", wcim0.awvalid, 1);
    check("w4_wvalid",  wcim0.wvalid, 1);
    check("w4_awaddr",  wcim0.awaddr, 32'h80);
    check("w4_wdata",   wcim0.wdata, 32'hCAFE_F00D);
    check("w4_wstrb",   wcim0.wstrb, 4'b0011);
    cyc();
    wcim0.wready = 0; wcim0.bvalid = 1; wcim0.bresp = 2'b10;
    #1;
    check("w4_w_drop",  wcim0.wvalid, 0);
    check("w4_aw_hold", wcim0.awvalid, 1);
    check("w4_bready0", wcim0.bready, 0);
    cyc(); #1;
    check("w4_aw_hold", wcim0.awvalid, 1);
    check("w4_bready0", wcim0.bready, 0);
    cyc();
    wcim0.bvalid = 0; wcim0.awready = 1;
    #1 check("w4_aw_hold", wcim0.awvalid, 1);
    cyc();
    wcim0.awready = 0;
    #1;
    check("w4_aw_drop", wcim0.awvalid, 0);
    check("w4_bready",  wcim0.bready, 1);
    check("w4_no_rsp",  rsp_valid, 0);
    cyc();
    wcim0.bvalid = 1; wcim0.bresp = 2'b11;
    #1 check("w4_no_rsp", rsp_valid, 0);
    cyc();
    wcim0.bvalid = 0;
    #1;
    check("w4_rsp",  rsp_valid, 4'b0001);
    check("w4_resp", rsp_resp, 2'b11);
    check("w4_data", rsp_data, 0);
    cyc(); #1;
    check("w4_rsp_once", rsp_valid, 0);
    check("w4_idle",     busy, 0);

    // Read from req3 that the slave never answers
    set_req(3, 1'b0, 32'h0000_0C00, 32'h0, 4'h0);
    req_valid = 4'b1000;
    #1 check("t5_grant", req_ready, 4'b1000);
`ifdef WCI_TIMEOUT_EN
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      req_valid = '0;
      #1;
      if (rsp_valid != 0) begin
        lat = k;
        break;
      end
    end
    check("t5_latency", lat, 17);
    check("t5_rsp",     rsp_valid, 4'b1000);
    check("t5_data",    rsp_data, 32'hDEAD_C0DE);
    check("t5_resp",    rsp_resp, 2'b10);
    check("t5_timeout", rsp_timeout, 1);
    check("t5_arvalid", wcim0.arvalid, 0);
    check("t5_rready",  wcim0.rready, 0);
    cyc(); #1;
    check("t5_idle", busy, 0);
`else
    stray = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      req_valid = '0;
      #1;
      if (rsp_valid != 0) stray++;
    end
    check("t5_no_rsp", stray, 0);
    check("t5_arvalid_hold", wcim0.arvalid, 1);
    check("t5_busy", busy, 1);
    wcim0.arready = 1;
    cyc();
    wcim0.arready = 0; wcim0.rvalid = 1; wcim0.rdata = 32'h0BAD_F00D; wcim0.rresp = 2'b00;
    #1 check("t5_rready", wcim0.rready, 1);
    cyc();
    wcim0.rvalid = 0;
    #1;
    check("t5_rsp",     rsp_valid, 4'b1000);
    check("t5_data",    rsp_data, 32'h0BAD_F00D);
    check("t5_timeout", rsp_timeout, 0);
    cyc(); #1;
    check("t5_idle", busy, 0);
`endif

    // Reset while in RESP_W: everything drops, no response, pointer restarts at req0
    set_req(1, 1'b1, 32'h0000_0200, 32'h1111_2222, 4'hF);
    req_valid = 4'b0010;
    #1 check("t6_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0; wcim0.awready = 1; wcim0.wready = 1;
    #1 check("t6_awvalid", wcim0.awvalid, 1);
    cyc();
    wcim0.awready = 0; wcim0.wready = 0; rst = 1'b1;
    #1 check("t6_bready", wcim0.bready, 1);
    cyc();
    set_req(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    req_valid = 4'hF;
    #1;
    check("t6_bready_drop", wcim0.bready, 0);
    check("t6_aw_drop",     wcim0.awvalid, 0);
    check("t6_busy",        busy, 0);
    check("t6_no_rsp",      rsp_valid, 0);
    check("t6_no_grant",    req_ready, 0);
    rst = 1'b0;
    #1 check("t6_grant_req0", req_ready, 4'b0001);
    cyc();
    req_valid = '0; wcim0.arready = 1;
    #1;
    check("t6_arvalid", wcim0.arvalid, 1);
    check("t6_araddr",  wcim0.araddr, 32'h300);
    check("t6_no_rsp",  rsp_valid, 0);
    cyc();
    wcim0.arready = 0; wcim0.rvalid = 1; wcim0.rdata = 32'h600D_0000; wcim0.rresp = 2'b00;
    #1 check("t6_rready", wcim0.rready, 1);
    cyc();
    wcim0.rvalid = 0;
    #1;
    check("t6_rsp",  rsp_valid, 4'b0001);
    check("t6_data", rsp_data, 32'h600D_0000);
    cyc(); #1;
    check("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
